// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 200000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int SH_W  = PTR_W + 1;

  logic [SH_W-1:0]  sh_s;
  logic [N_REQ-1:0] rot_s;
  logic [N_REQ-1:0] first_s;

  // Rotate so ptr+1 lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    sh_s    = SH_W'(i_ptr) + SH_W'(1);
    rot_s   = N_REQ'({i_req, i_req} >> sh_s);
    first_s = rot_s & (~rot_s + N_REQ'(1));
    o_grant = N_REQ'(({first_s, first_s} << sh_s) >> N_REQ);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART_TX among N_REQ byte requesters,
// with per-frame grant locking and a start-to-done watchdog.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_timeout,
  input  logic                    i_clr_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               timeout_q, timeout_d;

  logic [N_REQ-1:0]   arb_grant_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [PTR_W-1:0]   sel_idx_s;
  logic [TMR_W-1:0]   timer_inc_s;
  logic               timeout_set_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant_s)
  );

  // Steer the owner's inputs through the one-hot grant; others are ignored.
  always_comb begin
    sel_valid_s = |(i_req_valid & grant_q);
    sel_last_s  = |(i_req_last & grant_q);
    sel_data_s  = '0;
    sel_idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_data_s = sel_data_s | (i_req_data[k*DATA_W +: DATA_W] & {DATA_W{grant_q[k]}});
      sel_idx_s  = sel_idx_s  | (PTR_W'(k) & {PTR_W{grant_q[k]}});
    end
    timer_inc_s = (timer_q == TMR_W'(TIMEOUT_CYC)) ? timer_q : (timer_q + TMR_W'(1));
  end

  // Next-state logic for the grant / handshake sequencer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ready_d       = '0;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    timer_d       = timer_q;
    ptr_d         = ptr_q;
    timeout_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          grant_d = arb_grant_s;
          ready_d = arb_grant_s;
          state_d = LOAD;
        end else begin
          grant_d = '0;
        end
      end
      LOAD: begin
        if (sel_valid_s) begin
          tx_data_d = sel_data_s;
          last_d    = sel_last_s;
          state_d   = START;
        end else begin
          grant_d = '0;
          ptr_d   = sel_idx_s;
          state_d = IDLE;
        end
      end
      START: begin
        if (!i_tx_busy) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_inc_s;
        // Done is tested first so it beats a simultaneous watchdog expiry.
        if (i_tx_done) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = sel_idx_s;
            state_d = IDLE;
          end else begin
            ready_d = grant_q;
            state_d = LOAD;
          end
        end else if (timer_inc_s == TMR_W'(TIMEOUT_CYC - 1)) begin
          timeout_set_s = 1'b1;
          grant_d       = '0;
          ptr_d         = sel_idx_s;
          state_d       = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky error flag: a new abort wins over a clear in the same cycle.
  always_comb begin
    if (timeout_set_s) begin
      timeout_d = 1'b1;
    end else if (i_clr_err) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      ptr_q     <= PTR_W'(N_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  // Start is gated by the live busy input so the pulse leaves START in its own cycle.
  assign o_tx_start  = (state_q == START) && !i_tx_busy;
  assign o_busy      = (state_q != IDLE);
  assign o_grant     = grant_q;
  assign o_req_ready = ready_q;
  assign o_tx_data   = tx_data_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: per-cycle vector table plus
// hand-written sequences against a small UART_TX timing model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  req_valid, req_last;
  logic [N*DW-1:0] req_data;
  logic          tx_busy_v, tx_done_v, clr_err;
  logic          model_busy, model_done;
  logic [N-1:0]  o_req_ready, o_grant;
  logic          o_tx_start, o_busy, o_timeout;
  logic [DW-1:0] o_tx_data;

  int tests = 0, fails = 0, oh_err = 0, done_cnt = 0, done_dly = 0, tx_cnt = 0;
  logic start_seen = 1'b0;
  logic [11:0] start_log[$];

  uart_tx_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(o_req_ready), .o_grant(o_grant),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_busy(tx_busy_v | model_busy), .i_tx_done(tx_done_v | model_done),
    .o_busy(o_busy), .o_timeout(o_timeout), .i_clr_err(clr_err)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        busy;
    logic        done;
    logic [3:0]  e_ready;
    logic [3:0]  e_grant;
    logic        e_start;
    logic [7:0]  e_data;
    logic        e_busy;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Leaves the caller at the negedge of the start cycle.
  task automatic wait_start(input string name, input int bound, output int k);
    k = -1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (o_tx_start) begin
        k = c;
        break;
      end
      step();
    end
    if (k < 0) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!o_busy && !model_busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) bound_fail(name);
    step();
  endtask

  // UART_TX model: busy from the cycle after start, done pulse done_dly cycles after start.
  initial begin
    model_busy = 1'b0;
    model_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (model_busy) begin
        if (tx_cnt == done_dly - 1) begin
          model_done = 1'b1;
          model_busy = 1'b0;
          done_cnt++;
        end else begin
          tx_cnt++;
        end
      end else if (start_seen && done_dly > 0) begin
        model_busy = 1'b1;
        tx_cnt = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      start_seen = o_tx_start;
      if (o_tx_start) start_log.push_back({o_grant, o_tx_data});
      if (!$onehot0(o_grant) || !$onehot0(o_req_ready)) oh_err++;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k, rel, bi, base, n, first;
    logic seen2, hs1, hs2;
    logic [7:0] b1[3];
    logic [3:0] exp_g[5];
    logic [7:0] exp_d[5];

    vt[0]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1};
    vt[3]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b1};
    vt[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 8'hA5, 1'b1};
    vt[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b1};
    vt[6]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b1};
    vt[7]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    vt[8]  = '{4'b0110, 32'h0077_1100, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    vt[9]  = '{4'b0110, 32'h0077_1100, 4'b0100, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'hA5, 1'b1};
    vt[10] = '{4'b0110, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 8'h11, 1'b1};
    vt[11] = '{4'b0110, 32'h0077_2200, 4'b0110, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'h11, 1'b1};
    vt[12] = '{4'b0110, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h11, 1'b1};
    vt[13] = '{4'b0110, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 8'h22, 1'b1};
    vt[14] = '{4'b0110, 32'h0077_2200, 4'b0110, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 8'h22, 1'b1};
    vt[15] = '{4'b0100, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h22, 1'b0};
    vt[16] = '{4'b0000, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h22, 1'b1};
    vt[17] = '{4'b0000, 32'h0077_2200, 4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h22, 1'b0};

    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy_v = 1'b0; tx_done_v = 1'b0; clr_err = 1'b0; done_dly = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Per-cycle vectors, TX handshake driven directly.
    for (int i = 0; i < 18; i++) begin
      req_valid = vt[i].valid; req_data = vt[i].data; req_last = vt[i].last;
      tx_busy_v = vt[i].busy;  tx_done_v = vt[i].done;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(o_req_ready), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d_grant", i), 32'(o_grant),     32'(vt[i].e_grant));
      chk($sformatf("vec%0d_start", i), 32'(o_tx_start),  32'(vt[i].e_start));
      chk($sformatf("vec%0d_data", i),  32'(o_tx_data),   32'(vt[i].e_data));
      chk($sformatf("vec%0d_busy", i),  32'(o_busy),      32'(vt[i].e_busy));
      chk($sformatf("vec%0d_tmo", i),   32'(o_timeout),   32'd0);
      step();
    end
    tx_busy_v = 1'b0; tx_done_v = 1'b0; req_valid = '0;

    // Single byte, TX done 20 cycles after start.
    done_dly = 20;
    req_valid = 4'b0001; req_data = 32'h0000_00A5; req_last = 4'b0001;
    @(negedge clk); chk("single_ready_c0", 32'(o_req_ready), 32'd0); step();
    @(negedge clk); chk("single_ready_c1", 32'(o_req_ready), 32'h1); step();
    req_valid = '0;
    @(negedge clk); chk("single_start_c2", 32'(o_tx_start), 32'd1);
    chk("single_data_c2", 32'(o_tx_data), 32'hA5);
    rel = -1;
    for (int c = 3; c < 60; c++) begin
      step();
      @(negedge clk);
      if (o_grant == 4'b0000) begin
        rel = c;
        break;
      end
    end
    chk("single_release_cycle", 32'(rel), 32'd23);
    wait_idle("single_idle");

    // Round-robin after reset: 0,1,2,3,0.
    reset = 1'b0;
    step();
    reset = 1'b1;
    start_log.delete();
    req_valid = 4'b1111; req_data = 32'h1312_1110; req_last = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      step();
      if (start_log.size() >= 5) break;
    end
    req_valid = '0;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    chk("rr_start_count", 32'(start_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < start_log.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(start_log[i][11:8]), 32'(exp_g[i]));
      chk($sformatf("rr_data%0d", i),  32'(start_log[i][7:0]),  32'(exp_d[i]));
    end
    wait_idle("rr_idle");

    // Frame lock: req1 sends 11,22,33 while req2 waits.
    start_log.delete();
    base = done_cnt; seen2 = 1'b0; bi = 0;
    b1 = '{8'h11, 8'h22, 8'h33};
    req_data = {8'h00, 8'h44, 8'h11, 8'h00}; req_last = 4'b0100; req_valid = 4'b0110;
    for (int c = 0; c < 400 && start_log.size() < 4; c++) begin
      @(negedge clk);
      hs1 = o_req_ready[1] & req_valid[1];
      hs2 = o_req_ready[2] & req_valid[2];
      if (o_req_ready[2] && !seen2) begin
        seen2 = 1'b1;
        chk("lock_r2_after_33", 32'(done_cnt - base >= 3), 32'd1);
      end
      step();
      if (hs1) begin
        bi++;
        if (bi < 3) begin
          req_data[15:8] = b1[bi];
          req_last[1] = (bi == 2);
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      if (hs2) req_valid[2] = 1'b0;
    end
    req_valid = '0;
    chk("lock_seen_r2", 32'(seen2), 32'd1);
    chk("lock_start_count", 32'(start_log.size()), 32'd4);
    exp_g[0:3] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    exp_d[0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4 && i < start_log.size(); i++) begin
      chk($sformatf("lock_grant%0d", i), 32'(start_log[i][11:8]), 32'(exp_g[i]));
      chk($sformatf("lock_data%0d", i),  32'(start_log[i][7:0]),  32'(exp_d[i]));
    end
    wait_idle("lock_idle");

    // Watchdog: TX never completes for req3, then req0 served.
    done_dly = 0;
    req_data = {8'hD3, 8'h00, 8'h00, 8'hC0}; req_last = 4'b1001; req_valid = 4'b1001;
    wait_start("wd_start", 20, k);
    chk("wd_grant_first", 32'(o_grant), 32'h8);
    chk("wd_data_first", 32'(o_tx_data), 32'hD3);
    step();
    req_valid[3] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 49) begin
        chk("wd_tmo_at_49", 32'(o_timeout), 32'd0);
        chk("wd_grant_at_49", 32'(o_grant), 32'h8);
      end
      if (c == 50) begin
        chk("wd_tmo_at_50", 32'(o_timeout), 32'd1);
        chk("wd_grant_at_50", 32'(o_grant), 32'd0);
      end
      step();
    end
    done_dly = 20;
    wait_start("wd_next_start", 10, k);
    chk("wd_next_latency", 32'(k), 32'd1);
    chk("wd_next_grant", 32'(o_grant), 32'h1);
    chk("wd_next_data", 32'(o_tx_data), 32'hC0);
    step();
    req_valid = '0;
    clr_err = 1'b1;
    @(negedge clk); chk("wd_tmo_before_clr", 32'(o_timeout), 32'd1);
    step();
    clr_err = 1'b0;
    @(negedge clk); chk("wd_tmo_cleared", 32'(o_timeout), 32'd0);
    wait_idle("wd_idle");

    // Done at start+49 beats the watchdog.
    done_dly = 49;
    req_data = {8'h00, 8'h00, 8'hE1, 8'h00}; req_last = 4'b0010; req_valid = 4'b0010;
    wait_start("wd49_start", 20, k);
    step();
    req_valid = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 49) chk("wd49_grant_at_49", 32'(o_grant), 32'h2);
      if (c == 50) begin
        chk("wd49_tmo_at_50", 32'(o_timeout), 32'd0);
        chk("wd49_grant_at_50", 32'(o_grant), 32'd0);
      end
      step();
    end
    wait_idle("wd49_idle");

    // Busy guard: busy held through 10 START cycles.
    done_dly = 20;
    tx_busy_v = 1'b1;
    req_data = {8'h00, 8'hB2, 8'h00, 8'h00}; req_last = 4'b0100; req_valid = 4'b0100;
    n = 0; first = -1;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) req_valid = '0;
      if (c == 12) tx_busy_v = 1'b0;
      @(negedge clk);
      if (o_tx_start) begin
        n++;
        if (first < 0) first = c;
      end
      step();
    end
    chk("busy_start_pulses", 32'(n), 32'd1);
    chk("busy_start_cycle", 32'(first), 32'd12);
    wait_idle("busy_idle");

    // Async reset mid-frame, then requester 0 has first priority.
    req_data = {8'h00, 8'h00, 8'hF1, 8'h00}; req_last = 4'b0010; req_valid = 4'b0010;
    wait_start("rst_start", 20, k);
    step();
    req_valid = '0;
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_start", 32'(o_tx_start), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_tmo", 32'(o_timeout), 32'd0);
    req_data = {8'h00, 8'h00, 8'hA1, 8'hA0}; req_last = 4'b0011; req_valid = 4'b0011;
    step();
    reset = 1'b1;
    wait_start("rst_after_start", 100, k);
    chk("rst_after_grant", 32'(o_grant), 32'h1);
    chk("rst_after_data", 32'(o_tx_data), 32'hA0);
    step();
    req_valid = '0;
    wait_idle("rst_after_idle");

    chk("grant_ready_onehot0", 32'(oh_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
